// File: rtl/signal_debug_pkg.sv
// rtl/signal_debug_pkg.sv - shared state type and PRBS7 constants for the signal-debug path
package signal_debug_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   localparam logic [6:0] PRBS7_SEED   = 7'h7F;
   localparam int         PRBS7_TAP_HI = 6;
   localparam int         PRBS7_TAP_LO = 5;

   // One step of x^7 + x^6 + 1: shift left, XOR of the two taps enters bit 0
   function automatic logic [6:0] prbs7_next(input logic [6:0] lfsr);
      return {lfsr[5:0], lfsr[PRBS7_TAP_HI] ^ lfsr[PRBS7_TAP_LO]};
   endfunction

endpackage

// File: rtl/prbs7_gen.sv
// rtl/prbs7_gen.sv - PRBS7 generator with seed load and single-step advance
module prbs7_gen
   import signal_debug_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic advance,
   output logic bit_out
);

   logic [6:0] r_lfsr;

   // LFSR state: load has priority over advance so a held load pins the seed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= PRBS7_SEED;
      end else if (load) begin
         r_lfsr <= PRBS7_SEED;
      end else if (advance) begin
         r_lfsr <= prbs7_next(r_lfsr);
      end
   end

   assign bit_out = r_lfsr[PRBS7_TAP_HI];

endmodule

// File: rtl/signal_loopback_tester.sv
// rtl/signal_loopback_tester.sv - PRBS7 loopback source, lock tracker and error counter
module signal_loopback_tester
   import signal_debug_pkg::*;
#(
   parameter int DIV    = 50,
   parameter int LOCK_N = 16,
   parameter int LOSS_N = 4,
   parameter int ERR_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             tx_pin,
   input  logic             rx_pin,
   output logic             locked,
   output logic             err_led,
   output logic [ERR_W-1:0] err_count,
   output logic             run_led
);

   localparam int BC_W = $clog2(DIV);
   localparam int MC_W = $clog2(LOCK_N + 1);
   localparam int LC_W = $clog2(LOSS_N + 1);

   localparam logic [BC_W-1:0]  BC_LAST = BC_W'(DIV - 1);
   localparam logic [BC_W-1:0]  BC_PRE  = BC_W'(DIV - 2);
   localparam logic [BC_W-1:0]  BC_MID  = BC_W'(DIV / 2);
   localparam logic [BC_W-1:0]  BC_ONE  = BC_W'(1);
   localparam logic [MC_W-1:0]  MC_DONE = MC_W'(LOCK_N - 1);
   localparam logic [MC_W-1:0]  MC_ONE  = MC_W'(1);
   localparam logic [LC_W-1:0]  LC_DONE = LC_W'(LOSS_N - 1);
   localparam logic [LC_W-1:0]  LC_ONE  = LC_W'(1);
   localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

   state_t           r_state;
   logic [BC_W-1:0]  r_bit_cnt;
   logic [MC_W-1:0]  r_match_cnt;
   logic [LC_W-1:0]  r_miss_cnt;
   logic [ERR_W-1:0] r_err_cnt;
   logic             r_tx_pin;
   logic             r_locked;
   logic             r_err_led;
   logic             r_run_led;
   logic             r_rx_meta;
   logic             r_rx_sync;

   logic             w_prbs_bit;
   logic             w_load;
   logic             w_advance;
   logic             w_strobe;
   logic             w_wrap;
   logic             w_match;

   // The LFSR steps one cycle ahead of the bit wrap so tx_pin can register
   // the new bit directly from bit_out on the wrap edge.
   assign w_load    = (r_state == ST_IDLE) || !start;
   assign w_advance = (r_state != ST_IDLE) && start && (r_bit_cnt == BC_PRE);
   assign w_strobe  = (r_bit_cnt == BC_MID);
   assign w_wrap    = (r_bit_cnt == BC_LAST);
   assign w_match   = (r_rx_sync == r_tx_pin);

   prbs7_gen u_prbs (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (w_load),
      .advance (w_advance),
      .bit_out (w_prbs_bit)
   );

   // Two-flop synchronizer for the asynchronous echoed pin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b0;
         r_rx_sync <= 1'b0;
      end else begin
         r_rx_meta <= rx_pin;
         r_rx_sync <= r_rx_meta;
      end
   end

   // Run control FSM with bit timer, lock/loss counters and error accounting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= '0;
         r_match_cnt <= '0;
         r_miss_cnt  <= '0;
         r_err_cnt   <= '0;
         r_tx_pin    <= 1'b0;
         r_locked    <= 1'b0;
         r_err_led   <= 1'b0;
         r_run_led   <= 1'b0;
      end else if (!start) begin
         // Dropping start wins over everything, including a sample strobe;
         // the error tally is left visible until the next run begins.
         r_state     <= ST_IDLE;
         r_bit_cnt   <= '0;
         r_match_cnt <= '0;
         r_miss_cnt  <= '0;
         r_tx_pin    <= 1'b0;
         r_locked    <= 1'b0;
         r_run_led   <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         // Entering a fresh run: clean counters, first bit is the seed MSB
         r_state     <= ST_SYNC;
         r_bit_cnt   <= '0;
         r_match_cnt <= '0;
         r_miss_cnt  <= '0;
         r_err_cnt   <= '0;
         r_err_led   <= 1'b0;
         r_tx_pin    <= w_prbs_bit;
         r_locked    <= 1'b0;
         r_run_led   <= 1'b1;
      end else begin
         if (w_wrap) begin
            r_bit_cnt <= '0;
            r_tx_pin  <= w_prbs_bit;
         end else begin
            r_bit_cnt <= r_bit_cnt + BC_ONE;
         end

         if (w_strobe) begin
            if (r_state == ST_SYNC) begin
               if (!w_match) begin
                  r_match_cnt <= '0;
               end else if (r_match_cnt == MC_DONE) begin
                  r_state     <= ST_CHECK;
                  r_locked    <= 1'b1;
                  r_match_cnt <= '0;
                  r_miss_cnt  <= '0;
               end else begin
                  r_match_cnt <= r_match_cnt + MC_ONE;
               end
            end else if (r_state == ST_CHECK) begin
               if (w_match) begin
                  r_miss_cnt <= '0;
               end else begin
                  // The error is counted even on the mismatch that drops lock
                  if (r_err_cnt != '1) begin
                     r_err_cnt <= r_err_cnt + ERR_ONE;
                  end
                  r_err_led <= 1'b1;
                  if (r_miss_cnt == LC_DONE) begin
                     r_state     <= ST_SYNC;
                     r_locked    <= 1'b0;
                     r_miss_cnt  <= '0;
                     r_match_cnt <= '0;
                  end else begin
                     r_miss_cnt <= r_miss_cnt + LC_ONE;
                  end
               end
            end else begin
               r_state <= ST_IDLE;
            end
         end
      end
   end

   assign tx_pin    = r_tx_pin;
   assign locked    = r_locked;
   assign err_led   = r_err_led;
   assign err_count = r_err_cnt;
   assign run_led   = r_run_led;

endmodule

// File: tb/tb_signal_loopback_tester.sv
// tb/tb_signal_loopback_tester.sv - self-checking bench for signal_loopback_tester
module tb_signal_loopback_tester;

   localparam int DIV    = 8;
   localparam int LOCK_N = 16;
   localparam int LOSS_N = 4;
   localparam int ERR_W  = 3;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             tx_pin;
   logic             rx_pin;
   logic             locked;
   logic             err_led;
   logic [ERR_W-1:0] err_count;
   logic             run_led;

   logic             inv;
   logic             stuck;
   logic             r_echo;

   int               n_checks;
   int               n_errors;
   bit               q_tx[$];
   int               q_exp[$];

   signal_loopback_tester #(
      .DIV    (DIV),
      .LOCK_N (LOCK_N),
      .LOSS_N (LOSS_N),
      .ERR_W  (ERR_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .tx_pin    (tx_pin),
      .rx_pin    (rx_pin),
      .locked    (locked),
      .err_led   (err_led),
      .err_count (err_count),
      .run_led   (run_led)
   );

   always #5 clk = ~clk;

   // Echo block model: one register, optional inversion or stuck-low
   always @(posedge clk) r_echo <= tx_pin;
   assign rx_pin = stuck ? 1'b0 : (r_echo ^ inv);

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference sequence from the output-bit recurrence s[n] = s[n-7] ^ s[n-6]
   function automatic void push_prbs(input int n);
      bit s [0:511];
      for (int k = 0; k < n; k++) begin
         if (k < 7) s[k] = 1'b1;
         else       s[k] = s[k-7] ^ s[k-6];
         q_tx.push_back(s[k]);
      end
   endfunction

   task automatic restart_run();
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_locked(input int max_cycles, output int cycles);
      cycles = 0;
      while (locked !== 1'b1 && cycles < max_cycles) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic inject_bits(input int nbits);
      @(negedge clk);
      inv = 1'b1;
      repeat (nbits * DIV) @(negedge clk);
      inv = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++; if (tx_pin !== 1'b0)   $display("FAIL reset_tx: got %b expected 0", tx_pin);
      if (tx_pin !== 1'b0) n_errors++;
      n_checks++; if (locked !== 1'b0)   begin n_errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
      n_checks++; if (err_led !== 1'b0)  begin n_errors++; $display("FAIL reset_err_led: got %b expected 0", err_led); end
      n_checks++; if (err_count !== 3'd0) begin n_errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
      n_checks++; if (run_led !== 1'b0)  begin n_errors++; $display("FAIL reset_run_led: got %b expected 0", run_led); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (run_led !== 1'b0)  begin n_errors++; $display("FAIL idle_run_led: got %b expected 0", run_led); end
   endtask

   task automatic test_prbs_lock();
      int lock_at;
      bit exp_bit;
      lock_at = -1;
      push_prbs(254);
      restart_run();
      n_checks++; if (run_led !== 1'b1) begin n_errors++; $display("FAIL start_run_led: got %b expected 1", run_led); end
      for (int j = 0; j < 254 * DIV; j++) begin
         if (j > 0) @(negedge clk);
         if (locked === 1'b1 && lock_at < 0) lock_at = j;
         if (j % DIV == DIV / 2) begin
            exp_bit = q_tx.pop_front();
            n_checks++;
            if (tx_pin !== exp_bit) begin
               n_errors++;
               $display("FAIL tx_bit%0d: got %b expected %b", j / DIV, tx_pin, exp_bit);
            end
         end
      end
      n_checks++; if (lock_at != (LOCK_N - 1) * DIV + DIV / 2 + 1) begin
         n_errors++; $display("FAIL lock_latency: got %0d expected %0d", lock_at, (LOCK_N - 1) * DIV + DIV / 2 + 1);
      end
      n_checks++; if (err_count !== 3'd0) begin n_errors++; $display("FAIL clean_err_count: got %0d expected 0", err_count); end
      n_checks++; if (err_led !== 1'b0)   begin n_errors++; $display("FAIL clean_err_led: got %b expected 0", err_led); end
      n_checks++; if (locked !== 1'b1)    begin n_errors++; $display("FAIL clean_locked: got %b expected 1", locked); end
   endtask

   task automatic test_single_error();
      logic [ERR_W-1:0] exp_cnt;
      q_exp.push_back(1);
      inject_bits(1);
      repeat (2 * DIV) @(negedge clk);
      exp_cnt = ERR_W'(q_exp.pop_front());
      n_checks++; if (err_count !== exp_cnt) begin n_errors++; $display("FAIL single_err_count: got %0d expected %0d", err_count, exp_cnt); end
      n_checks++; if (err_led !== 1'b1)  begin n_errors++; $display("FAIL single_err_led: got %b expected 1", err_led); end
      n_checks++; if (locked !== 1'b1)   begin n_errors++; $display("FAIL single_locked: got %b expected 1", locked); end
   endtask

   task automatic test_loss_of_lock();
      int cyc;
      logic [ERR_W-1:0] exp_cnt;
      restart_run();
      wait_locked(40 * DIV, cyc);
      n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL loss_prelock: got %b expected 1", locked); end
      q_exp.push_back(LOSS_N);
      inject_bits(LOSS_N);
      repeat (4) @(negedge clk);
      exp_cnt = ERR_W'(q_exp.pop_front());
      n_checks++; if (err_count !== exp_cnt) begin n_errors++; $display("FAIL loss_err_count: got %0d expected %0d", err_count, exp_cnt); end
      n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL loss_locked: got %b expected 0", locked); end
      n_checks++; if (run_led !== 1'b1) begin n_errors++; $display("FAIL loss_run_led: got %b expected 1", run_led); end
      wait_locked(20 * DIV, cyc);
      cyc += 4;
      n_checks++; if (locked !== 1'b1 || cyc < 15 * DIV || cyc > 17 * DIV) begin
         n_errors++; $display("FAIL relock_time: got locked=%b after %0d cycles expected 1 within %0d..%0d", locked, cyc, 15 * DIV, 17 * DIV);
      end
      n_checks++; if (err_count !== 3'd4) begin n_errors++; $display("FAIL relock_err_count: got %0d expected 4", err_count); end
   endtask

   task automatic test_stuck();
      bit seen;
      seen = 1'b0;
      stuck = 1'b1;
      restart_run();
      for (int j = 0; j < 200 * DIV; j++) begin
         @(negedge clk);
         if (locked !== 1'b0) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL stuck_locked: got 1 expected 0"); end
      n_checks++; if (err_count !== 3'd0) begin n_errors++; $display("FAIL stuck_err_count: got %0d expected 0", err_count); end
      n_checks++; if (run_led !== 1'b1) begin n_errors++; $display("FAIL stuck_run_led: got %b expected 1", run_led); end
      stuck = 1'b0;
   endtask

   task automatic test_saturation();
      int cyc;
      int n_inv;
      int run;
      bit do_inv;
      logic [ERR_W-1:0] exp_cnt;
      restart_run();
      wait_locked(40 * DIV, cyc);
      n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL sat_prelock: got %b expected 1", locked); end
      n_inv = 0;
      run   = 0;
      @(negedge clk);
      for (int b = 0; b < 40; b++) begin
         do_inv = (run < LOSS_N - 2) && (n_inv < 9 || $urandom_range(0, 1) == 1);
         inv = do_inv;
         if (do_inv) begin n_inv++; run++; end
         else run = 0;
         repeat (DIV) @(negedge clk);
      end
      inv = 1'b0;
      q_exp.push_back(n_inv > 7 ? 7 : n_inv);
      repeat (2 * DIV) @(negedge clk);
      exp_cnt = ERR_W'(q_exp.pop_front());
      n_checks++; if (err_count !== exp_cnt) begin n_errors++; $display("FAIL sat_err_count: got %0d expected %0d", err_count, exp_cnt); end
      n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL sat_locked: got %b expected 1", locked); end
   endtask

   task automatic test_controls();
      int cyc;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (tx_pin !== 1'b0)    begin n_errors++; $display("FAIL async_tx: got %b expected 0", tx_pin); end
      n_checks++; if (locked !== 1'b0)    begin n_errors++; $display("FAIL async_locked: got %b expected 0", locked); end
      n_checks++; if (err_led !== 1'b0)   begin n_errors++; $display("FAIL async_err_led: got %b expected 0", err_led); end
      n_checks++; if (err_count !== 3'd0) begin n_errors++; $display("FAIL async_err_count: got %0d expected 0", err_count); end
      n_checks++; if (run_led !== 1'b0)   begin n_errors++; $display("FAIL async_run_led: got %b expected 0", run_led); end
      @(negedge clk);
      rst_n = 1'b1;
      wait_locked(40 * DIV, cyc);
      n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL ctl_relock: got %b expected 1", locked); end
      inject_bits(1);
      repeat (2 * DIV) @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      n_checks++; if (run_led !== 1'b0)   begin n_errors++; $display("FAIL stop_run_led: got %b expected 0", run_led); end
      n_checks++; if (locked !== 1'b0)    begin n_errors++; $display("FAIL stop_locked: got %b expected 0", locked); end
      n_checks++; if (tx_pin !== 1'b0)    begin n_errors++; $display("FAIL stop_tx: got %b expected 0", tx_pin); end
      n_checks++; if (err_count !== 3'd1) begin n_errors++; $display("FAIL stop_err_count: got %0d expected 1", err_count); end
      start = 1'b1;
      @(negedge clk);
      n_checks++; if (run_led !== 1'b1)   begin n_errors++; $display("FAIL rerun_run_led: got %b expected 1", run_led); end
      n_checks++; if (tx_pin !== 1'b1)    begin n_errors++; $display("FAIL rerun_tx: got %b expected 1", tx_pin); end
      n_checks++; if (err_count !== 3'd0) begin n_errors++; $display("FAIL rerun_err_count: got %0d expected 0", err_count); end
      n_checks++; if (err_led !== 1'b0)   begin n_errors++; $display("FAIL rerun_err_led: got %b expected 0", err_led); end
   endtask

   initial begin
      clk      = 1'b0;
      rst_n    = 1'b0;
      start    = 1'b0;
      inv      = 1'b0;
      stuck    = 1'b0;
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_prbs_lock();
      test_single_error();
      test_loss_of_lock();
      test_stuck();
      test_saturation();
      test_controls();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/signal_loopback_tester.md
# signal_loopback_tester

Self-checking stimulus source for the signal-debug path. It drives a PRBS7 bit stream onto an FPGA pin that feeds the pin-echo block's input. It samples the echoed pin coming back, achieves lock, and then counts bit errors. Status is shown on LEDs, so a board-level loopback can be checked without a logic analyser.

## Interface
Parameters:
- DIV, 50: clk cycles per transmitted bit; legal range ≥ 4.
- LOCK_N, 16: consecutive matching samples needed to declare lock.
- LOSS_N, 4: consecutive mismatches in CHECK that drop lock.
- ERR_W, 16: width of the error counter.

Ports:
- clk, input, 1: single system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: level enable. 1 runs the test; 0 returns to IDLE.
- tx_pin, output, 1: registered PRBS bit driven to the echo block's in_pin.
- rx_pin, input, 1: echoed signal from the echo block's out_pin; asynchronous.
- locked, output, 1: registered; 1 while in CHECK.
- err_led, output, 1: registered; sticky, set on the first error counted in CHECK.
- err_count, output, ERR_W: saturating count of mismatches seen in CHECK.
- run_led, output, 1: registered; 1 in any state other than IDLE.

## Operation
- rx_pin passes through a 2-flop synchronizer. Only the synchronized value is used.
- Bit timer bit_cnt counts 0..DIV-1 while not in IDLE.
  - On wrap (DIV-1 → 0), the PRBS advances and tx_pin takes the new bit.
  - Sample strobe fires at bit_cnt == DIV/2 (integer division). It compares the synchronized rx against the current tx_pin.
- PRBS7: polynomial x^7 + x^6 + 1, 7-bit LFSR, seed 7'h7F. Output bit is lfsr[6]. Shift left with feedback lfsr[6]^lfsr[5] into bit 0. Period is 127 bits.
- States:
  - IDLE: tx_pin = 0 and bit_cnt = 0. The LFSR is reloaded to the seed. Stay here while start = 0. Go to SYNC when start = 1.
  - SYNC: match_cnt counts consecutive matches and clears on any mismatch. When it reaches LOCK_N, go to CHECK. Errors are never counted in SYNC.
  - CHECK: locked = 1.
    - Each mismatch increments err_count (saturating at all-ones), sets err_led, and increments miss_cnt.
    - Each match clears miss_cnt.
    - When miss_cnt reaches LOSS_N, go to SYNC. err_count and err_led keep their values.
- start = 0 in any state → IDLE on the next edge. err_count and err_led are cleared only by reset or by the IDLE→SYNC transition. A new run therefore starts clean.
- Loop latency, measured from the tx_pin edge to the synchronized rx, must be < DIV/2 clk cycles. The echo path is 1 register and the synchronizer adds 2, so latency is 3.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, lfsr = 7'h7F, and bit_cnt, match_cnt and miss_cnt = 0.
  - Outputs during reset: tx_pin = 0, locked = 0, err_led = 0, err_count = 0, run_led = 0.
- Release of reset is synchronous to the next clk edge. Reset asserted mid-run aborts immediately; no partial state survives.
- start sampled 1 in IDLE:
  - The next edge enters SYNC; run_led = 1 and tx_pin = seed MSB (1).
  - The first sample strobe follows DIV/2 cycles later.
- All outputs are registered. locked, err_led and err_count update on the edge after the deciding sample strobe.
- Simultaneous events:
  - start deasserting on a sample-strobe cycle: IDLE wins and the sample is discarded.
  - A mismatch that reaches LOSS_N: the error is counted and SYNC is entered on the same edge.
- Saturation: err_count holds 2^ERR_W − 1 and never wraps.

## Structure
- Package signal_debug_pkg holds:
  - the state enum (IDLE, SYNC, CHECK);
  - PRBS7_SEED = 7'h7F;
  - PRBS7 tap positions (6, 5).
- Sub-module prbs7_gen: ports clk, rst_n, load, advance, bit_out. It is reusable by a future receive-side checker.
- Top level contains the synchronizer, bit timer, FSM and counters.

## Test plan
- Direct loopback: tie rx_pin to tx_pin through 1 register, DIV = 8, start = 1.
  - locked = 1 after 16 bit periods plus about 1 cycle.
  - err_count stays 0 for 254 bits.
  - tx_pin reproduces the PRBS7 sequence starting 1,1,1,1,1,1,1,0.
- Single injected error: in CHECK, invert rx for one bit period.
  - err_count = 1 and err_led = 1.
  - locked stays 1.
- Loss of lock: invert rx for 4 consecutive bits.
  - err_count = 4 and locked = 0 (SYNC).
  - After the inversion is removed, locked is 1 again after 16 bits and err_count is still 4.
- Stuck input: rx_pin held 0 from start.
  - locked never asserts within 200 bits.
  - err_count = 0.
- Saturation: ERR_W = 3, rx inverted at random in CHECK while staying under 4 consecutive mismatches.
  - err_count stops at 7.
- Controls: pull rst_n low mid-CHECK, then toggle start 1→0→1.
  - Asynchronous reset clears all outputs to 0 without waiting for a clk edge.
  - The start toggle returns to IDLE and clears err_count on re-entry to SYNC.
